bsg_cgol_output_serializer: RTL and testbench

Downstream neighbour of the Game-of-Life control/cell-array pair. Captures the finished board snapshot (`board_width_p`² bits) when control presents it valid, acknowledges with a single-cycle yumi, then streams it out in `data_width_p`-bit words over a valid/ready channel to the chip output link. It holds exactly one board at a time and returns to idle after the last word is accepted.

---
 rtl/bsg_cgol_pkg.sv | 7 +
 rtl/bsg_cgol_xor_accum.sv | 16 +
 rtl/bsg_cgol_output_serializer.sv | 67 ++++++
 tb/tb_bsg_cgol_output_serializer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/bsg_cgol_pkg.sv
// bsg_cgol_pkg: shared serializer state type and board word-count helper
package bsg_cgol_pkg;
  typedef enum logic {eIdle, eSend} bsg_cgol_ser_state_e;
  function automatic int num_words(input int board_width, input int data_width, input bit checksum);
    return (board_width * board_width + data_width - 1) / data_width + (checksum ? 1 : 0);
  endfunction
endpackage

// File: rtl/bsg_cgol_xor_accum.sv
// bsg_cgol_xor_accum: XOR accumulator with clear (priority) and enable
module bsg_cgol_xor_accum #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] sum_o
);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) sum_o <= '0;
    else if (clr_i) sum_o <= '0;
    else if (en_i) sum_o <= sum_o ^ data_i;
endmodule

// File: rtl/bsg_cgol_output_serializer.sv
// bsg_cgol_output_serializer: captures one board and streams it out as data_width_p-bit words
// Define BSG_CGOL_OUT_CHECKSUM_EN to append an XOR checksum word after the data words.
module bsg_cgol_output_serializer
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p = 32,
  parameter int data_width_p  = 32
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [board_width_p*board_width_p-1:0] board_i,
  input  logic                                   board_v_i,
  output logic                                   board_yumi_o,
  output logic [data_width_p-1:0]                data_o,
  output logic                                   v_o,
  input  logic                                   ready_i,
  output logic                                   last_o
);
`ifdef BSG_CGOL_OUT_CHECKSUM_EN
  localparam bit checksum_lp = 1'b1;
`else
  localparam bit checksum_lp = 1'b0;
`endif
  localparam int data_words_lp = num_words(board_width_p, data_width_p, 1'b0);
  localparam int num_words_lp  = num_words(board_width_p, data_width_p, checksum_lp);
  localparam int sr_w_lp       = data_words_lp * data_width_p;
  localparam int cnt_w_lp      = $clog2(num_words_lp + 1);
  bsg_cgol_ser_state_e state;
  logic [sr_w_lp-1:0]  sr;
  logic [cnt_w_lp-1:0] cnt;
  logic                send, hs, last_w;
  assign send         = state == eSend;
  assign hs           = send & ready_i;
  assign last_w       = cnt == cnt_w_lp'(num_words_lp - 1);
  assign board_yumi_o = reset_n_i & board_v_i & (~send | (hs & last_w));
  assign v_o          = send;
  assign last_o       = send & last_w;
  // shift register is padded to whole words so the tail of the last data word shifts in as zero
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= eIdle;
      cnt   <= '0;
      sr    <= '0;
    end else if (board_yumi_o) begin
      state <= eSend;
      cnt   <= '0;
      sr    <= sr_w_lp'(board_i);
    end else if (hs) begin
      state <= last_w ? eIdle : eSend;
      cnt   <= cnt + cnt_w_lp'(1);
      sr    <= sr >> data_width_p;
    end
`ifdef BSG_CGOL_OUT_CHECKSUM_EN
  logic [data_width_p-1:0] sum;
  bsg_cgol_xor_accum #(.width_p(data_width_p)) accum (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr_i    (board_yumi_o),
    .en_i     (hs & ~last_w),
    .data_i   (sr[data_width_p-1:0]),
    .sum_o    (sum)
  );
  assign data_o = last_w ? sum : sr[data_width_p-1:0];
`else
  assign data_o = sr[data_width_p-1:0];
`endif
endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
// tb_bsg_cgol_output_serializer: directed checks on a 4x4/8-bit and a 3x3/4-bit serializer
module tb_bsg_cgol_output_serializer;
`ifdef BSG_CGOL_OUT_CHECKSUM_EN
  localparam bit cks = 1'b1;
`else
  localparam bit cks = 1'b0;
`endif
  logic        clk = 0, rst_n;
  logic [15:0] a_board;
  logic        a_v, a_yumi, a_vo, a_rdy, a_last;
  logic [7:0]  a_data;
  logic [8:0]  b_board;
  logic        b_v, b_yumi, b_vo, b_rdy, b_last;
  logic [3:0]  b_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  bsg_cgol_output_serializer #(.board_width_p(4), .data_width_p(8)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .board_i(a_board), .board_v_i(a_v), .board_yumi_o(a_yumi),
    .data_o(a_data), .v_o(a_vo), .ready_i(a_rdy), .last_o(a_last));
  bsg_cgol_output_serializer #(.board_width_p(3), .data_width_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .board_i(b_board), .board_v_i(b_v), .board_yumi_o(b_yumi),
    .data_o(b_data), .v_o(b_vo), .ready_i(b_rdy), .last_o(b_last));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic [7:0] d, input logic l, input logic y);
    chk({tag, "_v"}, 32'(a_vo), 1);
    chk({tag, "_data"}, 32'(a_data), 32'(d));
    chk({tag, "_last"}, 32'(a_last), 32'(l));
    chk({tag, "_yumi"}, 32'(a_yumi), 32'(y));
  endtask
  initial begin
    rst_n = 0; a_v = 0; a_board = 0; a_rdy = 1; b_v = 0; b_board = 0; b_rdy = 1;
    tick; tick;
    a_v = 1; #1;
    chk("rst_v", 32'(a_vo), 0);
    chk("rst_last", 32'(a_last), 0);
    chk("rst_yumi", 32'(a_yumi), 0);
    chk("rst_data", 32'(a_data), 0);
    a_v = 0; rst_n = 1; tick;
    // single board, ready held high
    a_board = 16'hA5C3; a_v = 1; #1;
    chk("t1_yumi", 32'(a_yumi), 1);
    chk("t1_idle_v", 32'(a_vo), 0);
    tick; a_v = 0; #1;
    chk_a("t1_w0", 8'hC3, 0, 0);
    tick;
    chk_a("t1_w1", 8'hA5, !cks, 0);
    if (cks) begin tick; chk_a("t1_cks", 8'h66, 1, 0); end
    tick;
    chk("t1_done_v", 32'(a_vo), 0);
    // backpressure with a pending next board, then back-to-back reload
    a_v = 1; #1; tick;
    a_rdy = 0; #1;
    chk_a("bp_w0", 8'hC3, 0, 0);
    for (int i = 0; i < 5; i++) begin tick; chk_a("bp_hold", 8'hC3, 0, 0); end
    a_rdy = 1; #1;
    chk("bp_rel_yumi", 32'(a_yumi), 0);
    tick; a_board = 16'h1234; #1;
    chk_a("b2b_a5", 8'hA5, !cks, !cks);
    if (cks) begin tick; chk_a("b2b_cks", 8'h66, 1, 1); end
    tick; a_v = 0; #1;
    chk_a("b2b_w0", 8'h34, 0, 0);
    tick;
    chk_a("b2b_w1", 8'h12, !cks, 0);
    if (cks) begin tick; chk_a("b2b_cks2", 8'h26, 1, 0); end
    tick;
    chk("b2b_done_v", 32'(a_vo), 0);
    // async reset while the second word is pending
    a_board = 16'hA5C3; a_v = 1; tick; a_v = 0; #1;
    chk_a("ar_w0", 8'hC3, 0, 0);
    tick; a_rdy = 0; #1;
    chk_a("ar_w1", 8'hA5, !cks, 0);
    a_v = 1; rst_n = 0; #1;
    chk("ar_v", 32'(a_vo), 0);
    chk("ar_last", 32'(a_last), 0);
    chk("ar_yumi", 32'(a_yumi), 0);
    tick;
    rst_n = 1; a_board = 16'h1234; a_rdy = 1; #1;
    chk("ar_rel_yumi", 32'(a_yumi), 1);
    chk("ar_rel_v", 32'(a_vo), 0);
    tick; a_v = 0; #1;
    chk_a("ar_restart_w0", 8'h34, 0, 0);
    tick;
    chk_a("ar_restart_w1", 8'h12, !cks, 0);
    if (cks) begin tick; chk_a("ar_cks", 8'h26, 1, 0); end
    tick;
    chk("ar_done_v", 32'(a_vo), 0);
    // 3x3 board, 4-bit words, zero-padded final word
    b_board = 9'h1AB; b_v = 1; #1;
    chk("b_yumi", 32'(b_yumi), 1);
    tick; b_v = 0; #1;
    chk("b_w0", 32'(b_data), 4'hB);
    chk("b_w0_last", 32'(b_last), 0);
    tick;
    chk("b_w1", 32'(b_data), 4'hA);
    chk("b_w1_last", 32'(b_last), 0);
    tick;
    chk("b_w2", 32'(b_data), 4'h1);
    chk("b_w2_last", 32'(b_last), 32'(!cks));
    chk("b_w2_v", 32'(b_vo), 1);
    if (cks) begin
      tick;
      chk("b_cks", 32'(b_data), 4'h0);
      chk("b_cks_last", 32'(b_last), 1);
    end
    tick;
    chk("b_done_v", 32'(b_vo), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
